// File: rtl/tl_arb2.sv
// tl_arb2 -- two-master TileLink-UL arbiter.
//
// Merges the A channels of masters m0 and m1 onto a single slave A channel
// through a one-entry output register. Multi-beat Put bursts lock the grant
// to their issuing master, and grants otherwise rotate round-robin. The
// D-channel responses are routed back combinationally using the master-index
// bit prepended to the slave-side source field.
//
// Ports:
//   clock, reset            sole clock (rising edge); async active-high reset
//   m{0,1}_a_*              master A channels (valid/ready + payload)
//   m{0,1}_d_*              master D channels (valid/ready + payload)
//   s_a_*                   slave A channel, source is {master, source}
//   s_d_*                   slave D channel, source[SRC_W] selects the master
module tl_arb2 #(
    parameter int SRC_W = 3,
    parameter int AW    = 32,
    parameter int DW    = 128
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               m0_a_valid,
    output logic               m0_a_ready,
    input  logic [2:0]         m0_a_opcode,
    input  logic [2:0]         m0_a_param,
    input  logic [7:0]         m0_a_size,
    input  logic [SRC_W-1:0]   m0_a_source,
    input  logic [AW-1:0]      m0_a_address,
    input  logic [DW/8-1:0]    m0_a_mask,
    input  logic [DW-1:0]      m0_a_data,
    input  logic               m0_a_corrupt,

    input  logic               m1_a_valid,
    output logic               m1_a_ready,
    input  logic [2:0]         m1_a_opcode,
    input  logic [2:0]         m1_a_param,
    input  logic [7:0]         m1_a_size,
    input  logic [SRC_W-1:0]   m1_a_source,
    input  logic [AW-1:0]      m1_a_address,
    input  logic [DW/8-1:0]    m1_a_mask,
    input  logic [DW-1:0]      m1_a_data,
    input  logic               m1_a_corrupt,

    output logic               m0_d_valid,
    input  logic               m0_d_ready,
    output logic [2:0]         m0_d_opcode,
    output logic [1:0]         m0_d_param,
    output logic [7:0]         m0_d_size,
    output logic [SRC_W-1:0]   m0_d_source,
    output logic [2:0]         m0_d_sink,
    output logic               m0_d_denied,
    output logic [DW-1:0]      m0_d_data,
    output logic               m0_d_corrupt,

    output logic               m1_d_valid,
    input  logic               m1_d_ready,
    output logic [2:0]         m1_d_opcode,
    output logic [1:0]         m1_d_param,
    output logic [7:0]         m1_d_size,
    output logic [SRC_W-1:0]   m1_d_source,
    output logic [2:0]         m1_d_sink,
    output logic               m1_d_denied,
    output logic [DW-1:0]      m1_d_data,
    output logic               m1_d_corrupt,

    output logic               s_a_valid,
    input  logic               s_a_ready,
    output logic [2:0]         s_a_opcode,
    output logic [2:0]         s_a_param,
    output logic [7:0]         s_a_size,
    output logic [SRC_W:0]     s_a_source,
    output logic [AW-1:0]      s_a_address,
    output logic [DW/8-1:0]    s_a_mask,
    output logic [DW-1:0]      s_a_data,
    output logic               s_a_corrupt,

    input  logic               s_d_valid,
    output logic               s_d_ready,
    input  logic [2:0]         s_d_opcode,
    input  logic [1:0]         s_d_param,
    input  logic [7:0]         s_d_size,
    input  logic [SRC_W:0]     s_d_source,
    input  logic [2:0]         s_d_sink,
    input  logic               s_d_denied,
    input  logic [DW-1:0]      s_d_data,
    input  logic               s_d_corrupt
);

    // Arbitration state
    logic       q_valid;
    logic       prio;
    logic       lock;
    logic       owner;
    logic [3:0] beats_left;

    // Granted master's A payload
    logic               grant;
    logic               can_load;
    logic               xfer;
    logic               g_valid;
    logic [2:0]         g_opcode;
    logic [2:0]         g_param;
    logic [7:0]         g_size;
    logic [SRC_W-1:0]   g_source;
    logic [AW-1:0]      g_address;
    logic [DW/8-1:0]    g_mask;
    logic [DW-1:0]      g_data;
    logic               g_corrupt;
    logic [4:0]         beats;

    always_comb begin
        if (lock)
            grant = owner;
        else if (m0_a_valid != m1_a_valid)
            grant = m1_a_valid;
        else
            grant = prio;
    end

    assign can_load   = !q_valid || s_a_ready;
    assign m0_a_ready = can_load && !grant && !reset;
    assign m1_a_ready = can_load &&  grant && !reset;

    always_comb begin
        if (grant) begin
            g_valid   = m1_a_valid;
            g_opcode  = m1_a_opcode;
            g_param   = m1_a_param;
            g_size    = m1_a_size;
            g_source  = m1_a_source;
            g_address = m1_a_address;
            g_mask    = m1_a_mask;
            g_data    = m1_a_data;
            g_corrupt = m1_a_corrupt;
        end else begin
            g_valid   = m0_a_valid;
            g_opcode  = m0_a_opcode;
            g_param   = m0_a_param;
            g_size    = m0_a_size;
            g_source  = m0_a_source;
            g_address = m0_a_address;
            g_mask    = m0_a_mask;
            g_data    = m0_a_data;
            g_corrupt = m0_a_corrupt;
        end
    end

    assign xfer = g_valid && can_load && !reset;

    // Only Put messages larger than one 16-byte beat are multi-beat;
    // sizes above 256 bytes are not supported and fall to 1 beat.
    always_comb begin
        beats = 5'd1;
        if (g_opcode == 3'd0 || g_opcode == 3'd1) begin
            case (g_size)
                8'd5:    beats = 5'd2;
                8'd6:    beats = 5'd4;
                8'd7:    beats = 5'd8;
                8'd8:    beats = 5'd16;
                default: beats = 5'd1;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_valid     <= 1'b0;
            s_a_opcode  <= '0;
            s_a_param   <= '0;
            s_a_size    <= '0;
            s_a_source  <= '0;
            s_a_address <= '0;
            s_a_mask    <= '0;
            s_a_data    <= '0;
            s_a_corrupt <= 1'b0;
            prio        <= 1'b0;
            lock        <= 1'b0;
            owner       <= 1'b0;
            beats_left  <= '0;
        end else if (xfer) begin
            q_valid     <= 1'b1;
            s_a_opcode  <= g_opcode;
            s_a_param   <= g_param;
            s_a_size    <= g_size;
            s_a_source  <= {grant, g_source};
            s_a_address <= g_address;
            s_a_mask    <= g_mask;
            s_a_data    <= g_data;
            s_a_corrupt <= g_corrupt;
            if (lock) begin
                // Continuation beat of a locked burst; the last one releases
                // the lock and hands priority to the other master.
                beats_left <= beats_left - 4'd1;
                if (beats_left == 4'd1) begin
                    lock <= 1'b0;
                    prio <= ~owner;
                end
            end else if (beats > 5'd1) begin
                lock       <= 1'b1;
                owner      <= grant;
                beats_left <= 4'(beats - 5'd1);
            end else begin
                prio <= ~grant;
            end
        end else if (s_a_ready) begin
            q_valid <= 1'b0;
        end
    end

    assign s_a_valid = q_valid;

    // D routing: purely combinational, selected by the prepended master bit
    logic d_sel;
    assign d_sel      = s_d_source[SRC_W];
    assign m0_d_valid = s_d_valid && !d_sel;
    assign m1_d_valid = s_d_valid &&  d_sel;
    assign s_d_ready  = d_sel ? m1_d_ready : m0_d_ready;

    assign m0_d_opcode  = s_d_opcode;
    assign m0_d_param   = s_d_param;
    assign m0_d_size    = s_d_size;
    assign m0_d_source  = s_d_source[SRC_W-1:0];
    assign m0_d_sink    = s_d_sink;
    assign m0_d_denied  = s_d_denied;
    assign m0_d_data    = s_d_data;
    assign m0_d_corrupt = s_d_corrupt;

    assign m1_d_opcode  = s_d_opcode;
    assign m1_d_param   = s_d_param;
    assign m1_d_size    = s_d_size;
    assign m1_d_source  = s_d_source[SRC_W-1:0];
    assign m1_d_sink    = s_d_sink;
    assign m1_d_denied  = s_d_denied;
    assign m1_d_data    = s_d_data;
    assign m1_d_corrupt = s_d_corrupt;

endmodule

// File: tb/tb_tl_arb2.sv
module tb_tl_arb2;

    localparam int SRC_W = 3;
    localparam int AW    = 32;
    localparam int DW    = 128;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic               m0_a_valid = 0, m1_a_valid = 0;
    logic               m0_a_ready, m1_a_ready;
    logic [2:0]         m0_a_opcode = 0, m1_a_opcode = 0;
    logic [2:0]         m0_a_param = 0, m1_a_param = 0;
    logic [7:0]         m0_a_size = 0, m1_a_size = 0;
    logic [SRC_W-1:0]   m0_a_source = 0, m1_a_source = 0;
    logic [AW-1:0]      m0_a_address = 0, m1_a_address = 0;
    logic [DW/8-1:0]    m0_a_mask = 0, m1_a_mask = 0;
    logic [DW-1:0]      m0_a_data = 0, m1_a_data = 0;
    logic               m0_a_corrupt = 0, m1_a_corrupt = 0;

    logic               m0_d_valid, m1_d_valid;
    logic               m0_d_ready = 0, m1_d_ready = 0;
    logic [2:0]         m0_d_opcode, m1_d_opcode;
    logic [1:0]         m0_d_param, m1_d_param;
    logic [7:0]         m0_d_size, m1_d_size;
    logic [SRC_W-1:0]   m0_d_source, m1_d_source;
    logic [2:0]         m0_d_sink, m1_d_sink;
    logic               m0_d_denied, m1_d_denied;
    logic [DW-1:0]      m0_d_data, m1_d_data;
    logic               m0_d_corrupt, m1_d_corrupt;

    logic               s_a_valid;
    logic               s_a_ready = 0;
    logic [2:0]         s_a_opcode;
    logic [2:0]         s_a_param;
    logic [7:0]         s_a_size;
    logic [SRC_W:0]     s_a_source;
    logic [AW-1:0]      s_a_address;
    logic [DW/8-1:0]    s_a_mask;
    logic [DW-1:0]      s_a_data;
    logic               s_a_corrupt;

    logic               s_d_valid = 0;
    logic               s_d_ready;
    logic [2:0]         s_d_opcode = 0;
    logic [1:0]         s_d_param = 0;
    logic [7:0]         s_d_size = 0;
    logic [SRC_W:0]     s_d_source = 0;
    logic [2:0]         s_d_sink = 0;
    logic               s_d_denied = 0;
    logic [DW-1:0]      s_d_data = 0;
    logic               s_d_corrupt = 0;

    int unsigned pass_cnt = 0;
    int unsigned chk_cnt  = 0;

    tl_arb2 #(.SRC_W(SRC_W), .AW(AW), .DW(DW)) dut (
        .clock(clock), .reset(reset),
        .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
        .m0_a_param(m0_a_param), .m0_a_size(m0_a_size), .m0_a_source(m0_a_source),
        .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data),
        .m0_a_corrupt(m0_a_corrupt),
        .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
        .m1_a_param(m1_a_param), .m1_a_size(m1_a_size), .m1_a_source(m1_a_source),
        .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data),
        .m1_a_corrupt(m1_a_corrupt),
        .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_opcode(m0_d_opcode),
        .m0_d_param(m0_d_param), .m0_d_size(m0_d_size), .m0_d_source(m0_d_source),
        .m0_d_sink(m0_d_sink), .m0_d_denied(m0_d_denied), .m0_d_data(m0_d_data),
        .m0_d_corrupt(m0_d_corrupt),
        .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_opcode(m1_d_opcode),
        .m1_d_param(m1_d_param), .m1_d_size(m1_d_size), .m1_d_source(m1_d_source),
        .m1_d_sink(m1_d_sink), .m1_d_denied(m1_d_denied), .m1_d_data(m1_d_data),
        .m1_d_corrupt(m1_d_corrupt),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
        .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
        .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
        .s_a_corrupt(s_a_corrupt),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
        .s_d_param(s_d_param), .s_d_size(s_d_size), .s_d_source(s_d_source),
        .s_d_sink(s_d_sink), .s_d_denied(s_d_denied), .s_d_data(s_d_data),
        .s_d_corrupt(s_d_corrupt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            pass_cnt++;
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        m0_a_valid = 0;
        m1_a_valid = 0;
        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
    endtask

    initial begin
        // Reset state
        s_a_ready = 1;
        m0_a_valid = 1;
        m1_a_valid = 1;
        tick();
        check("rst_s_a_valid", 128'(s_a_valid), 128'd0);
        check("rst_m0_ready", 128'(m0_a_ready), 128'd0);
        check("rst_m1_ready", 128'(m1_a_ready), 128'd0);
        check("rst_s_a_addr", 128'(s_a_address), 128'd0);
        m0_a_valid = 0;
        m1_a_valid = 0;
        reset = 0;
        #1;

        // Single Get from m0
        m0_a_valid = 1; m0_a_opcode = 3'd4; m0_a_size = 8'd4;
        m0_a_source = 3'd2; m0_a_address = 32'h8000_0000;
        #1;
        check("get_m0_ready", 128'(m0_a_ready), 128'd1);
        check("get_m1_ready", 128'(m1_a_ready), 128'd0);
        tick();
        m0_a_valid = 0;
        check("get_s_valid", 128'(s_a_valid), 128'd1);
        check("get_s_source", 128'(s_a_source), 128'h2);
        check("get_s_addr", 128'(s_a_address), 128'h8000_0000);
        check("get_s_opcode", 128'(s_a_opcode), 128'd4);
        tick();
        check("get_drained", 128'(s_a_valid), 128'd0);

        // D response to m0
        s_d_valid = 1; s_d_source = 4'b0010; s_d_data = 128'hABCD; s_d_opcode = 3'd1;
        m0_d_ready = 1; m1_d_ready = 0;
        #1;
        check("d0_m0_valid", 128'(m0_d_valid), 128'd1);
        check("d0_m1_valid", 128'(m1_d_valid), 128'd0);
        check("d0_source", 128'(m0_d_source), 128'd2);
        check("d0_data", m0_d_data, 128'hABCD);
        check("d0_s_ready", 128'(s_d_ready), 128'd1);
        s_d_valid = 0;

        // Both masters Get every cycle: grants alternate m0, m1, ...
        do_reset();
        s_a_ready = 1;
        m0_a_valid = 1; m0_a_opcode = 3'd4; m0_a_size = 8'd4; m0_a_source = 3'd1;
        m1_a_valid = 1; m1_a_opcode = 3'd4; m1_a_size = 8'd4; m1_a_source = 3'd6;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_m0_ready", 128'(m0_a_ready), 128'((i % 2) == 0));
            check("rr_m1_ready", 128'(m1_a_ready), 128'((i % 2) == 1));
            tick();
            check("rr_s_valid", 128'(s_a_valid), 128'd1);
            check("rr_s_source", 128'(s_a_source), ((i % 2) == 0) ? 128'h1 : 128'hE);
        end
        m0_a_valid = 0; m1_a_valid = 0;
        tick();

        // m1 4-beat PutFullData burst with m0 competing
        do_reset();
        s_a_ready = 1;
        m1_a_valid = 1; m1_a_opcode = 3'd0; m1_a_size = 8'd6; m1_a_source = 3'd3;
        m1_a_data = 128'd100;
        #1;
        check("bst_b0_m1_ready", 128'(m1_a_ready), 128'd1);
        tick();
        check("bst_b0_data", s_a_data, 128'd100);
        check("bst_b0_size", 128'(s_a_size), 128'd6);
        check("bst_b0_source", 128'(s_a_source), 128'hB);
        m0_a_valid = 1; m0_a_opcode = 3'd4; m0_a_size = 8'd4; m0_a_source = 3'd5;
        m1_a_data = 128'd101;
        #1;
        check("bst_b1_m0_ready", 128'(m0_a_ready), 128'd0);
        check("bst_b1_m1_ready", 128'(m1_a_ready), 128'd1);
        tick();
        check("bst_b1_data", s_a_data, 128'd101);
        // Owner idles: lock still holds m0 off
        m1_a_valid = 0;
        #1;
        check("bst_idle_m0_ready", 128'(m0_a_ready), 128'd0);
        tick();
        check("bst_idle_s_valid", 128'(s_a_valid), 128'd0);
        m1_a_valid = 1; m1_a_data = 128'd102;
        tick();
        check("bst_b2_data", s_a_data, 128'd102);
        m1_a_data = 128'd103;
        #1;
        check("bst_b3_m0_ready", 128'(m0_a_ready), 128'd0);
        tick();
        check("bst_b3_data", s_a_data, 128'd103);
        check("bst_b3_source", 128'(s_a_source), 128'hB);
        // Burst done; m1 now issues a Get, m0 must win next, then m1
        m1_a_opcode = 3'd4; m1_a_size = 8'd4;
        #1;
        check("bst_post_m0_ready", 128'(m0_a_ready), 128'd1);
        check("bst_post_m1_ready", 128'(m1_a_ready), 128'd0);
        tick();
        check("bst_post_src0", 128'(s_a_source), 128'h5);
        check("bst_post2_m1_ready", 128'(m1_a_ready), 128'd1);
        tick();
        check("bst_post_src1", 128'(s_a_source), 128'hB);
        m0_a_valid = 0; m1_a_valid = 0;
        tick();

        // Backpressure: one buffered beat, s_a_ready low for 5 cycles
        do_reset();
        s_a_ready = 0;
        m0_a_valid = 1; m0_a_opcode = 3'd4; m0_a_size = 8'd4;
        m0_a_source = 3'd0; m0_a_address = 32'h0000_1234;
        tick();
        m0_a_address = 32'h0000_5678;
        m1_a_valid = 1; m1_a_opcode = 3'd4; m1_a_size = 8'd4; m1_a_source = 3'd7;
        for (int i = 0; i < 5; i++) begin
            check("bp_s_valid", 128'(s_a_valid), 128'd1);
            check("bp_addr", 128'(s_a_address), 128'h1234);
            check("bp_m0_ready", 128'(m0_a_ready), 128'd0);
            check("bp_m1_ready", 128'(m1_a_ready), 128'd0);
            tick();
        end
        s_a_ready = 1;
        #1;
        check("bp_rel_m1_ready", 128'(m1_a_ready), 128'd1);
        tick();
        check("bp_rel_source", 128'(s_a_source), 128'hF);
        m0_a_valid = 0; m1_a_valid = 0;
        tick();
        check("bp_empty", 128'(s_a_valid), 128'd0);

        // D response routed to m1 with backpressure
        s_d_valid = 1; s_d_source = 4'b1101; s_d_data = 128'h55;
        m0_d_ready = 1; m1_d_ready = 0;
        #1;
        check("d1_m1_valid", 128'(m1_d_valid), 128'd1);
        check("d1_m0_valid", 128'(m0_d_valid), 128'd0);
        check("d1_s_ready_lo", 128'(s_d_ready), 128'd0);
        m1_d_ready = 1;
        #1;
        check("d1_s_ready_hi", 128'(s_d_ready), 128'd1);
        check("d1_source", 128'(m1_d_source), 128'd5);
        check("d1_data", m1_d_data, 128'h55);
        s_d_valid = 0;

        // Reset during beat 2 of an m1 4-beat put
        s_a_ready = 1;
        m1_a_valid = 1; m1_a_opcode = 3'd1; m1_a_size = 8'd6; m1_a_source = 3'd2;
        tick();
        tick();
        check("mid_s_valid_pre", 128'(s_a_valid), 128'd1);
        #2;
        reset = 1;
        #1;
        check("mid_s_valid", 128'(s_a_valid), 128'd0);
        check("mid_m0_ready", 128'(m0_a_ready), 128'd0);
        check("mid_m1_ready", 128'(m1_a_ready), 128'd0);
        m1_a_valid = 0;
        tick();
        reset = 0;
        #1;
        // prio back to m0 and lock cleared: both valid -> m0 wins
        m0_a_valid = 1; m0_a_opcode = 3'd4; m0_a_size = 8'd4; m0_a_source = 3'd1;
        m1_a_valid = 1; m1_a_opcode = 3'd4; m1_a_size = 8'd4; m1_a_source = 3'd4;
        #1;
        check("post_rst_m0_ready", 128'(m0_a_ready), 128'd1);
        check("post_rst_m1_ready", 128'(m1_a_ready), 128'd0);
        m0_a_valid = 0;
        #1;
        check("post_rst_m1_only", 128'(m1_a_ready), 128'd1);
        tick();
        check("post_rst_source", 128'(s_a_source), 128'hC);
        check("post_rst_opcode", 128'(s_a_opcode), 128'd4);
        m1_a_valid = 0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
